// File: rtl/ram_port_arbiter.sv
// Arbitrates the single-port program/data RAM between the CPU memory port and the
// program loader: loader preferred, CPU starvation bounded, optional loader lock.
module ram_port_arbiter #(
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic              ld_lock,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, CPU_OWN, LD_OWN, LD_LOCK} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   burst_q, burst_d;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [DATA_W-1:0]  cpu_rdata_q, ld_rdata_q;
  logic               cpu_turn;

  // CPU is owed the port once the loader has taken MAX_BURST grants in a row
  assign cpu_turn = cpu_req && (burst_q == CNT_W'(MAX_BURST));

  // Grant decision, next owner and starvation counter
  always_comb begin
    cpu_gnt = 1'b0;
    ld_gnt  = 1'b0;
    state_d = state_q;
    burst_d = burst_q;
    if (rst_n) begin
      if (state_q == LD_LOCK) begin
        ld_gnt  = ld_req;
        state_d = ld_lock ? LD_LOCK : IDLE;
      end else begin
        if (ld_req && !cpu_turn) begin
          ld_gnt = 1'b1;
        end else if (cpu_req) begin
          cpu_gnt = 1'b1;
        end
        if (ld_gnt) begin
          state_d = ld_lock ? LD_LOCK : LD_OWN;
        end else if (cpu_gnt) begin
          state_d = CPU_OWN;
        end else begin
          state_d = IDLE;
        end
        if (cpu_gnt || !cpu_req) begin
          burst_d = '0;
        end else if (ld_gnt && (burst_q != CNT_W'(MAX_BURST))) begin
          burst_d = burst_q + CNT_W'(1);
        end
      end
    end
  end

  // RAM-side mux; address and data hold their last issued values when idle
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = addr_q;
    ram_wdata = wdata_q;
    if (ld_gnt) begin
      ram_we    = ld_we;
      ram_addr  = ld_addr;
      ram_wdata = ld_wdata;
    end else if (cpu_gnt) begin
      ram_we    = cpu_we;
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
    end
  end

  assign cpu_stall = cpu_req & ~cpu_gnt;
  assign cpu_rdata = cpu_rvalid ? ram_rdata : cpu_rdata_q;
  assign ld_rdata  = ld_rvalid ? ram_rdata : ld_rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      burst_q     <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rvalid  <= 1'b0;
      ld_rvalid   <= 1'b0;
      cpu_rdata_q <= '0;
      ld_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      burst_q    <= burst_d;
      cpu_rvalid <= cpu_gnt & ~cpu_we;
      ld_rvalid  <= ld_gnt & ~ld_we;
      if (cpu_gnt || ld_gnt) begin
        addr_q  <= ram_addr;
        wdata_q <= ram_wdata;
      end
      if (cpu_rvalid) cpu_rdata_q <= ram_rdata;
      if (ld_rvalid)  ld_rdata_q  <= ram_rdata;
    end
  end

endmodule
